// File: rtl/bit4_subtractor.sv
// ============================================================================
// bit4_subtractor : 8-stage pipelined 4-bit ripple-borrow subtractor,
// {Bout,D} = A - B - Bin. Optional macro BIT4_SUB_OVERFLOW_EN adds OV.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit4_subtractor #(
  parameter int LATENCY = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Bin,
  output logic       out_valid,
  output logic [3:0] D,
  output logic       Bout
`ifdef BIT4_SUB_OVERFLOW_EN
  ,
  output logic       OV
`endif
);

  if (LATENCY != 8) begin : g_latency_check
    $error("bit4_subtractor: LATENCY must be 8");
  end

  logic [3:0]         w_br;
  logic [3:0]         w_d;
  logic [LATENCY-1:0] vld_q;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    localparam int SKEW   = 2 * i;
    localparam int DESKEW = 6 - 2 * i;

    logic a_op;
    logic b_op;
    logic br_in;
    logic hd_q;
    logic hb_q;
    logic brp_q;
    logic d_q;
    logic br_q;

    if (SKEW == 0) begin : g_noskew
      assign a_op = A[i];
      assign b_op = B[i];
    end else begin : g_skew
      logic [SKEW-1:0] a_sk_q;
      logic [SKEW-1:0] b_sk_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_sk_q <= '0;
          b_sk_q <= '0;
        end else if (en) begin
          a_sk_q <= {a_sk_q[SKEW-2:0], A[i]};
          b_sk_q <= {b_sk_q[SKEW-2:0], B[i]};
        end
      end
      assign a_op = a_sk_q[SKEW-1];
      assign b_op = b_sk_q[SKEW-1];
    end

    if (i == 0) begin : g_brin_ext
      assign br_in = Bin;
    end else begin : g_brin_chain
      assign br_in = w_br[i-1];
    end

    // Incoming borrow is re-registered with the half-subtractor so both
    // operands of the combine stage belong to the same operation.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        hd_q  <= 1'b0;
        hb_q  <= 1'b0;
        brp_q <= 1'b0;
        d_q   <= 1'b0;
        br_q  <= 1'b0;
      end else if (en) begin
        hd_q  <= a_op ^ b_op;
        hb_q  <= ~a_op & b_op;
        brp_q <= br_in;
        d_q   <= hd_q ^ brp_q;
        br_q  <= hb_q | (~hd_q & brp_q);
      end
    end

    assign w_br[i] = br_q;

    if (DESKEW == 0) begin : g_nodeskew
      assign w_d[i] = d_q;
    end else begin : g_deskew
      logic [DESKEW-1:0] dsk_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dsk_q <= '0;
        end else if (en) begin
          dsk_q <= {dsk_q[DESKEW-2:0], d_q};
        end
      end
      assign w_d[i] = dsk_q[DESKEW-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[LATENCY-2:0], in_valid};
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign D         = w_d;
  assign Bout      = w_br[3];

`ifdef BIT4_SUB_OVERFLOW_EN
  logic [LATENCY-1:0] sa_q;
  logic [LATENCY-1:0] sb_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sa_q <= '0;
      sb_q <= '0;
    end else if (en) begin
      sa_q <= {sa_q[LATENCY-2:0], A[3]};
      sb_q <= {sb_q[LATENCY-2:0], B[3]};
    end
  end

  assign OV = (sa_q[LATENCY-1] ^ sb_q[LATENCY-1]) & (w_d[3] ^ sa_q[LATENCY-1]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_bit4_subtractor.sv
// ============================================================================
// tb_bit4_subtractor : directed/table-driven bench for bit4_subtractor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bit4_subtractor;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic       out_valid;
  logic [3:0] D;
  logic       Bout;
`ifdef BIT4_SUB_OVERFLOW_EN
  logic       OV;
`endif

  bit4_subtractor dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .D         (D),
    .Bout      (Bout)
`ifdef BIT4_SUB_OVERFLOW_EN
    ,
    .OV        (OV)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic [3:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic       bo;
    logic       ov;
    int         t;
  } exp_t;

  exp_t q[$];
  int   nchk;
  int   nerr;
  int   adv_cnt;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, then check any emerging result.
  task automatic cyc(input logic e, input logic v, input logic [3:0] a, input logic [3:0] b,
                     input logic bi, input logic [3:0] ed, input logic ebo, input logic eov);
    logic adv;
    exp_t x;
    en = e; in_valid = v; A = a; B = b; Bin = bi;
    @(posedge clk);
    adv = e && rstn;
    if (adv) begin
      adv_cnt++;
      if (v) q.push_back('{d: ed, bo: ebo, ov: eov, t: adv_cnt});
    end
    #1;
    if (adv && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        x = q.pop_front();
        chk("D", int'(D), int'(x.d));
        chk("Bout", int'(Bout), int'(x.bo));
        chk("latency", adv_cnt - x.t, 7);
`ifdef BIT4_SUB_OVERFLOW_EN
        chk("OV", int'(OV), int'(x.ov));
`endif
      end
    end
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle();
    chk("drain_queue_empty", q.size(), 0);
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic bi);
    logic [4:0] r;
    r = {1'b0, a} - {1'b0, b} - {4'b0, bi};
    cyc(1'b1, 1'b1, a, b, bi, r[3:0], r[4], (a[3] != b[3]) && (r[3] != a[3]));
  endtask

  vec_t tbl[9];
  logic [3:0] sd;
  logic       sbo;
`ifdef BIT4_SUB_OVERFLOW_EN
  logic       sov;
`endif

  initial begin
    nchk = 0; nerr = 0; adv_cnt = 0;
    rstn = 1'b0; en = 1'b0; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0;

    tbl[0] = '{a: 4'd3,  b: 4'd9,  bi: 1'b0, d: 4'hA, bo: 1'b1, ov: 1'b1};
    tbl[1] = '{a: 4'd0,  b: 4'd0,  bi: 1'b1, d: 4'hF, bo: 1'b1, ov: 1'b0};
    tbl[2] = '{a: 4'd15, b: 4'd15, bi: 1'b1, d: 4'hF, bo: 1'b1, ov: 1'b0};
    tbl[3] = '{a: 4'd9,  b: 4'd3,  bi: 1'b0, d: 4'h6, bo: 1'b0, ov: 1'b1};
    tbl[4] = '{a: 4'd8,  b: 4'd1,  bi: 1'b0, d: 4'h7, bo: 1'b0, ov: 1'b1};
    tbl[5] = '{a: 4'd7,  b: 4'd1,  bi: 1'b0, d: 4'h6, bo: 1'b0, ov: 1'b0};
    tbl[6] = '{a: 4'd7,  b: 4'd8,  bi: 1'b0, d: 4'hF, bo: 1'b1, ov: 1'b1};
    tbl[7] = '{a: 4'd0,  b: 4'd15, bi: 1'b0, d: 4'h1, bo: 1'b1, ov: 1'b0};
    tbl[8] = '{a: 4'd15, b: 4'd0,  bi: 1'b1, d: 4'hE, bo: 1'b0, ov: 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_D", int'(D), 0);
    chk("reset_Bout", int'(Bout), 0);
`ifdef BIT4_SUB_OVERFLOW_EN
    chk("reset_OV", int'(OV), 0);
`endif
    rstn = 1'b1;

    // Single op: 9 - 3 - 0, latency and isolation
    cyc(1'b1, 1'b1, 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
    chk("single_pre_valid", int'(out_valid), 0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("single_pre_valid", int'(out_valid), 0);
    end
    idle();
    chk("single_valid", int'(out_valid), 1);
    idle();
    chk("single_post_valid", int'(out_valid), 0);

    // Table vectors back-to-back
    for (int i = 0; i < 9; i++)
      cyc(1'b1, 1'b1, tbl[i].a, tbl[i].b, tbl[i].bi, tbl[i].d, tbl[i].bo, tbl[i].ov);
    drain();

    // Stall with ops in flight; first result visible while frozen
    for (int i = 0; i < 4; i++) op(4'(i * 5 + 2), 4'(i * 3 + 7), 1'(i));
    for (int i = 0; i < 4; i++) idle();
    chk("stall_pre_valid", int'(out_valid), 1);
    sd = D; sbo = Bout;
`ifdef BIT4_SUB_OVERFLOW_EN
    sov = OV;
`endif
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_D", int'(D), int'(sd));
      chk("stall_Bout", int'(Bout), int'(sbo));
`ifdef BIT4_SUB_OVERFLOW_EN
      chk("stall_OV", int'(OV), int'(sov));
`endif
    end
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) op(4'(i + 1), 4'(12 - i), 1'(i & 1));
    chk("pre_reset_valid", int'(out_valid), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_D", int'(D), 0);
    chk("async_rst_Bout", int'(Bout), 0);
    q.delete();
    cyc(1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b0);
    rstn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      idle();
      chk("post_rst_valid", int'(out_valid), 0);
    end
    op(4'd12, 4'd5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("post_rst_new_pre", int'(out_valid), 0);
    end
    idle();
    chk("post_rst_new_valid", int'(out_valid), 1);
    drain();

    // Exhaustive sweep with random stalls
    for (int k = 0; k < 512; k++) begin
      logic [3:0] a;
      logic [3:0] b;
      logic       bi;
      logic [4:0] r;
      a = 4'(k >> 5); b = 4'(k >> 1); bi = 1'(k);
      r = {1'b0, a} - {1'b0, b} - {4'b0, bi};
      while ($urandom_range(0, 2) == 0)
        cyc(1'b0, 1'b1, ~a, b, ~bi, 4'h0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, a, b, bi, r[3:0], r[4], (a[3] != b[3]) && (r[3] != a[3]));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

`default_nettype wire
